dot_product_engine: RTL and testbench

- Parametrised successor to the fixed two-term multiply-add operation block.
- Computes a signed dot product of up to TERMS operand pairs, using one multiply-accumulate per cycle, with a selectable alternating-sign mode.
- Sits between the co-processor command decoder (upstream STB/BUSY) and the result writeback stage (downstream STB/BUSY).
- Self-contained: instantiates no multiplier or adder submodules.

---
 rtl/dot_product_engine.sv | 169 ++++++++++++++++
 tb/tb_dot_product_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_engine.sv
// Signed dot-product engine: one multiply-accumulate per cycle over up to
// TERMS latched operand pairs, with optional alternating-sign accumulation.
// Upstream and downstream use a STB/BUSY handshake.
module dot_product_engine #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned TERMS     = 4,
  parameter int unsigned ACC_WIDTH = 34
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TERMS*WIDTH-1:0]     in_a,
  input  logic [TERMS*WIDTH-1:0]     in_b,
  input  logic [$clog2(TERMS):0]     in_len,
  input  logic                       in_mode,
  input  logic                       in_stb,
  output logic                       in_busy,
  output logic [ACC_WIDTH-1:0]       out_result,
  output logic                       out_stb,
  input  logic                       out_busy
);

  localparam int unsigned IW = $clog2(TERMS);
  localparam int unsigned LW = IW + 1;
  localparam int unsigned PW = 2 * WIDTH;

  // Elaboration-time parameter sanity checks
  if (TERMS < 2) begin : g_chk_terms
    $error("dot_product_engine: TERMS must be at least 2");
  end
  if (ACC_WIDTH < PW + IW) begin : g_chk_acc
    $error("dot_product_engine: ACC_WIDTH too small for exact result");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                       state_q, state_nxt;
  logic        [IW-1:0]         idx_q, idx_nxt;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_nxt;
  logic                         busy_nxt;
  logic                         stb_nxt;
  logic        [ACC_WIDTH-1:0]  result_nxt;

  // Latched transaction operands
  logic signed [WIDTH-1:0]      a_q [TERMS];
  logic signed [WIDTH-1:0]      b_q [TERMS];
  logic        [LW-1:0]         len_q;
  logic                         mode_q;

  logic                         load_c;
  logic        [LW-1:0]         eff_len_c;
  logic signed [PW-1:0]         prod_c;
  logic signed [ACC_WIDTH-1:0]  term_c;
  logic signed [ACC_WIDTH-1:0]  acc_sum_c;
  logic                         last_c;

  // Clamp requested length to the number of available terms
  always_comb begin
    eff_len_c = in_len;
    if (in_len > LW'(TERMS)) begin
      eff_len_c = LW'(TERMS);
    end
  end

  // Current product term, sign-extended and signed according to mode/index.
  // A zero-length transaction runs one MAC cycle with a zero term so that
  // its result appears one cycle after acceptance like any other.
  always_comb begin
    prod_c = PW'(a_q[idx_q]) * PW'(b_q[idx_q]);
    term_c = '0;
    if (len_q != '0) begin
      term_c = ACC_WIDTH'(prod_c);
    end
    if (mode_q && idx_q[0]) begin
      acc_sum_c = acc_q - term_c;
    end else begin
      acc_sum_c = acc_q + term_c;
    end
    last_c = (len_q == '0) || (LW'(idx_q) == (len_q - LW'(1)));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt  = state_q;
    idx_nxt    = idx_q;
    acc_nxt    = acc_q;
    busy_nxt   = in_busy;
    stb_nxt    = out_stb;
    result_nxt = out_result;
    load_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_stb) begin
          load_c    = 1'b1;
          acc_nxt   = '0;
          idx_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        acc_nxt = acc_sum_c;
        if (last_c) begin
          result_nxt = acc_sum_c;
          stb_nxt    = 1'b1;
          state_nxt  = S_OUT;
        end else begin
          idx_nxt = idx_q + IW'(1);
        end
      end
      S_OUT: begin
        if (!out_busy) begin
          stb_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
        stb_nxt   = 1'b0;
      end
    endcase
  end

  // Control state and outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      in_busy    <= 1'b0;
      out_stb    <= 1'b0;
      out_result <= '0;
    end else begin
      state_q    <= state_nxt;
      idx_q      <= idx_nxt;
      acc_q      <= acc_nxt;
      in_busy    <= busy_nxt;
      out_stb    <= stb_nxt;
      out_result <= result_nxt;
    end
  end

  // Operand capture at acceptance; upstream may change its ports afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q  <= '0;
      mode_q <= 1'b0;
    end else if (load_c) begin
      len_q  <= eff_len_c;
      mode_q <= in_mode;
    end
  end

  // Operand vectors are pure datapath and need no reset
  always_ff @(posedge clk) begin
    if (load_c) begin
      for (int i = 0; i < TERMS; i++) begin
        a_q[i] <= in_a[i*WIDTH +: WIDTH];
        b_q[i] <= in_b[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine (WIDTH=16, TERMS=4, ACC_WIDTH=34).
module tb_dot_product_engine;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned TERMS     = 4;
  localparam int unsigned ACC_WIDTH = 34;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [TERMS*WIDTH-1:0] in_a;
  logic [TERMS*WIDTH-1:0] in_b;
  logic [2:0]             in_len;
  logic                   in_mode;
  logic                   in_stb;
  logic                   in_busy;
  logic [ACC_WIDTH-1:0]   out_result;
  logic                   out_stb;
  logic                   out_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  dot_product_engine #(
    .WIDTH(WIDTH), .TERMS(TERMS), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_len(in_len),
    .in_mode(in_mode), .in_stb(in_stb), .in_busy(in_busy),
    .out_result(out_result), .out_stb(out_stb), .out_busy(out_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  // Reference dot product straight from the arithmetic definition
  function automatic logic [33:0] dot_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] len, input logic mode);
    longint sum;
    longint p;
    int n;
    sum = 0;
    n = (len > 3'd4) ? 4 : int'(len);
    for (int i = 0; i < n; i++) begin
      p = longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
      if (mode && (i % 2 == 1)) sum -= p;
      else                      sum += p;
    end
    return 34'(sum);
  endfunction

  // Transaction-level model: busy window, result countdown, held output
  logic        m_busy = 1'b0;
  logic        m_stb  = 1'b0;
  logic [33:0] m_res  = '0;
  logic [33:0] m_pend = '0;
  int          m_cnt  = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_stb  = 1'b0;
      m_res  = '0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (in_stb) begin
        m_busy = 1'b1;
        m_pend = dot_ref(in_a, in_b, in_len, in_mode);
        m_cnt  = (in_len == 3'd0) ? 1 : ((in_len > 3'd4) ? 4 : int'(in_len));
      end
    end else if (!m_stb) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_stb = 1'b1;
        m_res = m_pend;
      end
    end else if (!out_busy) begin
      m_stb  = 1'b0;
      m_busy = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_in_busy", 64'(in_busy), 64'(m_busy));
      chk("model_out_stb", 64'(out_stb), 64'(m_stb));
      chk("model_out_result", 64'(out_result), 64'(m_res));
    end
  end

  // Issue one request (caller is just after an edge with the engine idle),
  // check latency and result, optionally hold out_busy, then hand off.
  task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input logic [2:0] len,
                         input logic mode, input logic [33:0] exp_res, input int exp_lat,
                         input int hold);
    int n;
    in_a = a; in_b = b; in_len = len; in_mode = mode; in_stb = 1'b1;
    chk("ref_pin", 64'(dot_ref(a, b, len, mode)), 64'(exp_res));
    @(posedge clk); #1;
    chk("busy_at_accept", 64'(in_busy), 64'd1);
    in_stb  = 1'b0;
    in_a    = {$urandom, $urandom};
    in_b    = {$urandom, $urandom};
    in_len  = 3'($urandom);
    in_mode = 1'($urandom);
    n = 0;
    while (!out_stb && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("stb_timeout", 64'(out_stb), 64'd1);
    chk("latency", 64'(n), 64'(exp_lat));
    chk("result", 64'(out_result), 64'(exp_res));
    for (int k = 0; k < hold; k++) begin
      in_stb = k[0];
      in_a   = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("hold_stb", 64'(out_stb), 64'd1);
      chk("hold_busy", 64'(in_busy), 64'd1);
      chk("hold_result", 64'(out_result), 64'(exp_res));
    end
    in_stb   = 1'b0;
    out_busy = 1'b0;
    @(posedge clk); #1;
    chk("handoff_busy", 64'(in_busy), 64'd0);
    chk("handoff_stb", 64'(out_stb), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v1a, v1b, vneg, vmax;
    v1a  = pack4(1, 2, 3, 4);
    v1b  = pack4(5, 6, 7, 8);
    vneg = pack4(-32768, -32768, -32768, -32768);
    vmax = pack4(32767, 32767, 32767, 32767);

    rst = 1'b0; in_stb = 1'b0; out_busy = 1'b0;
    in_a = '0; in_b = '0; in_len = '0; in_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_busy", 64'(in_busy), 64'd0);
    chk("reset_out_stb", 64'(out_stb), 64'd0);
    chk("reset_out_result", 64'(out_result), 64'd0);
    chk_en = 1'b1;
    rst = 1'b1;

    // Plain and alternating sums
    run_txn(v1a, v1b, 3'd4, 1'b0, 34'd70, 4, 0);
    run_txn(v1a, v1b, 3'd4, 1'b1, 34'h3_FFFF_FFEE, 4, 0);
    run_txn(v1a, v1b, 3'd3, 1'b1, 34'd14, 3, 0);

    // Extreme operands, no wrap
    run_txn(vneg, vneg, 3'd4, 1'b0, 34'h1_0000_0000, 4, 0);
    run_txn(vmax, vneg, 3'd4, 1'b0, 34'(-64'sd4294836224), 4, 0);

    // Zero length and clamped length
    run_txn(v1a, v1b, 3'd0, 1'b0, 34'd0, 1, 0);
    run_txn(v1a, v1b, 3'd7, 1'b0, 34'd70, 4, 0);
    run_txn(v1a, v1b, 3'd1, 1'b1, 34'd5, 1, 0);

    // Downstream backpressure, then an immediate back-to-back request
    out_busy = 1'b1;
    run_txn(v1a, v1b, 3'd4, 1'b1, 34'h3_FFFF_FFEE, 4, 10);
    run_txn(v1a, v1b, 3'd2, 1'b0, 34'd17, 2, 0);

    // Reset in the middle of a MAC sequence
    in_a = v1a; in_b = v1b; in_len = 3'd4; in_mode = 1'b0; in_stb = 1'b1;
    @(posedge clk); #1;
    in_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midreset_in_busy", 64'(in_busy), 64'd0);
    chk("midreset_out_stb", 64'(out_stb), 64'd0);
    chk("midreset_out_result", 64'(out_result), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("no_stale_stb", 64'(out_stb), 64'd0);
    end
    run_txn(v1a, v1b, 3'd4, 1'b0, 34'd70, 4, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
